imem_dual_fetch: RTL and testbench
==================================

Name: imem_dual_fetch

Overview:
Instruction memory that sits directly upstream of the core and answers its fetch address (addr_o, 10-bit word index) with two consecutive 32-bit instructions on a 64-bit bus (data_i).
- Two interleaved 32-bit banks, even and odd word, so an unaligned pair (odd start address) is served in one access.
- A boot loader FSM fills the banks from a byte stream after reset and holds the core until the program is loaded.

Parameters:
ADDR_W, 10, word-address width; memory holds 2**ADDR_W 32-bit words.
BANK_W, ADDR_W-1, row-index width per bank.
BOOT_SKIP, 0, when 1 the loader is bypassed and the FSM goes straight to RUN after reset; banks keep their init contents.

Ports:
clock_i  in  1  single core clock; all logic rising-edge.
reset_i  in  1  synchronous, active-high reset.
addr_i  in  ADDR_W  fetch word address, driven by core addr_o.
data_o  out  64  [31:0] = word at addr_i, [63:32] = word at addr_i+1 (mod 2**ADDR_W); to core data_i.
load_valid_i  in  1  loader byte valid.
load_data_i  in  8  loader byte.
load_ready_o  out  1  loader can accept a byte this cycle.
core_hold_o  out  1  high while loading; the core must not advance fetch.
load_done_o  out  1  high once the FSM is in RUN.

Behaviour:
- Reset values: data_o=0, load_ready_o=0, core_hold_o=1, load_done_o=0. Byte counter, word count and write pointer all 0. State goes to LEN_LO, or to RUN if BOOT_SKIP=1.
- Reset mid-load: the load restarts from LEN_LO. Contents already written stay in the banks (no clearing).
- FSM states:
  - LEN_LO: ready=1. On a valid byte, latch count[7:0] and go to LEN_HI.
  - LEN_HI: ready=1. On a valid byte, latch count[15:8]. Count 0 or count > 2**ADDR_W is clamped to 2**ADDR_W. Then go to DATA.
  - DATA: ready=1. Bytes arrive little-endian; four bytes assemble one word. On the 4th byte, write the word to word address wptr and increment wptr. When wptr reaches count, go to RUN on the same edge as the last write. load_ready_o drops the cycle after.
  - RUN: ready=0, core_hold_o=0, load_done_o=1. Bytes are ignored. RUN is left only by reset.
- Handshake: a byte transfers when load_valid_i && load_ready_o at the clock edge. Gaps in valid are allowed; the partial word is held.
- Bank mapping: word w lives in bank[w[0]] at row w[ADDR_W-1:1]. A loader write touches exactly one bank.
- Fetch, RUN only. Read latency is 1 cycle (synchronous bank read, registered output). With a = addr_i:
  - Even a: even row a>>1, odd row a>>1; data_o = {odd, even}.
  - Odd a: odd row a>>1, even row (a>>1)+1, wrapping to row 0 at the top; data_o = {even, odd}. The lane swap uses a[0] registered alongside the read.
  - a = 2**ADDR_W-1: the high lane returns word 0.
- Outside RUN, data_o = 0 (all-zero word = invalid inst; the core is held anyway). Bank ports are owned by the loader.
- Simultaneous load write and fetch cannot occur: the loader owns the banks whenever state != RUN.
- The first valid data_o appears the cycle after the transition to RUN, for the addr_i presented on that cycle.

Decomposition:
- Shared package (defines header alongside the pipeline includes): BOOT_LEN_LO/LEN_HI/DATA/RUN state encodings (2-bit), IMEM_ADDR_W default, IMEM_FETCH_W=64.
- One sub-module, imem_bank: 2**BANK_W x 32 single-port synchronous RAM with write enable and optional init file. Instantiated twice (even/odd).
- FSM, byte assembler, address increment/wrap and lane swap stay in imem_dual_fetch.

Test Plan:
- Reset with BOOT_SKIP=0 -> core_hold_o=1, load_ready_o=1 next cycle, load_done_o=0, data_o=0.
- Load len=4 (bytes 04 00), then words 0x00000013, 0x00100093, 0x00200113, 0x00300193 as LE bytes, valid every cycle -> load_done_o rises after the 18th byte; ready low next cycle; core_hold_o=0.
- After that load, addr_i=0 -> next cycle data_o=0x00100093_00000013. addr_i=1 -> data_o=0x00200113_00100093. addr_i=2 -> data_o=0x00300193_00200113.
- Load with load_valid_i toggling 1/0 and a 5-cycle gap mid-word -> identical contents and data_o as the back-to-back load.
- Load len=0 (clamps to 1024) with word k=k. Then addr_i=1023 -> data_o=0x00000000_000003FF (wrap). addr_i=512 -> data_o=0x00000201_00000200.
- Assert reset_i after 6 data bytes of a len=4 load, then reload len=1 word 0xDEADBEEF -> load_done_o after 6 bytes; addr_i=0 gives data_o[31:0]=0xDEADBEEF; word 1 retains its previously written value.

Source files
------------

// File: rtl/imem_dual_fetch_pkg.sv
// Shared definitions for the dual-bank instruction memory: boot FSM encodings
// and default widths.
package imem_dual_fetch_pkg;

  localparam int IMEM_ADDR_W  = 10;
  localparam int IMEM_FETCH_W = 64;

  typedef enum logic [1:0] {
    BOOT_LEN_LO = 2'd0,
    BOOT_LEN_HI = 2'd1,
    BOOT_DATA   = 2'd2,
    BOOT_RUN    = 2'd3
  } boot_state_e;

endpackage

// File: rtl/imem_dual_fetch_bank.sv
// Single-port synchronous RAM, 32-bit words, one registered read per cycle.
// The read returns the old contents when the same row is written.
module imem_bank
  import imem_dual_fetch_pkg::*;
#(
  parameter int BANK_W = IMEM_ADDR_W - 1
) (
  input  logic              clock_i,
  input  logic              we_i,
  input  logic [BANK_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**BANK_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clock_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_dual_fetch.sv
// Dual-bank instruction memory returning two consecutive words per fetch,
// with a boot loader that fills the banks from a little-endian byte stream.
module imem_dual_fetch
  import imem_dual_fetch_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int BANK_W    = ADDR_W - 1,
  parameter bit BOOT_SKIP = 1'b0
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [ADDR_W-1:0]       addr_i,
  output logic [IMEM_FETCH_W-1:0] data_o,
  input  logic                    load_valid_i,
  input  logic [7:0]              load_data_i,
  output logic                    load_ready_o,
  output logic                    core_hold_o,
  output logic                    load_done_o
);

  localparam int          DEPTH       = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam boot_state_e RESET_STATE = BOOT_SKIP ? BOOT_RUN : BOOT_LEN_LO;

  boot_state_e       state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_buf_q, word_buf_d;
  logic              ready_q, hold_q, done_q, rd_en_q, swap_q;

  logic              xfer, wr_en, run;
  logic [15:0]       len16;
  logic [31:0]       wr_word;
  logic [BANK_W-1:0] fetch_row, fetch_row_nx, even_addr, odd_addr;
  logic [31:0]       even_rd, odd_rd;

  // Loader handshake: a byte moves on a rising edge where load_valid_i and
  // load_ready_o are both high; the sender may drop valid at any time.
  assign xfer    = load_valid_i && ready_q;
  assign run     = (state_q == BOOT_RUN);
  assign len16   = {load_data_i, len_lo_q};
  assign wr_word = {load_data_i, word_buf_q};

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    byte_cnt_d = byte_cnt_q;
    word_buf_d = word_buf_q;
    wr_en      = 1'b0;
    case (state_q)
      BOOT_LEN_LO: begin
        if (xfer) begin
          len_lo_d = load_data_i;
          state_d  = BOOT_LEN_HI;
        end
      end
      BOOT_LEN_HI: begin
        if (xfer) begin
          // A zero or oversized length means "fill the whole memory".
          if (len16 == 16'd0 || len16 > 16'(DEPTH)) begin
            count_d = FULL_CNT;
          end else begin
            count_d = len16[ADDR_W:0];
          end
          state_d = BOOT_DATA;
        end
      end
      BOOT_DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    word_buf_d[7:0]   = load_data_i;
            2'd1:    word_buf_d[15:8]  = load_data_i;
            2'd2:    word_buf_d[23:16] = load_data_i;
            default: begin
              wr_en  = 1'b1;
              wptr_d = wptr_q + 1'b1;
              if (wptr_d == count_q) begin
                state_d = BOOT_RUN;
              end
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  // Odd fetches take the even word from the next row, wrapping at the top.
  assign fetch_row    = addr_i[ADDR_W-1:1];
  assign fetch_row_nx = fetch_row + 1'b1;
  assign even_addr    = run ? (addr_i[0] ? fetch_row_nx : fetch_row) : wptr_q[ADDR_W-1:1];
  assign odd_addr     = run ? fetch_row : wptr_q[ADDR_W-1:1];

  imem_bank #(.BANK_W(BANK_W)) u_bank_even (
    .clock_i (clock_i),
    .we_i    (wr_en && !wptr_q[0]),
    .addr_i  (even_addr),
    .wdata_i (wr_word),
    .rdata_o (even_rd)
  );

  imem_bank #(.BANK_W(BANK_W)) u_bank_odd (
    .clock_i (clock_i),
    .we_i    (wr_en && wptr_q[0]),
    .addr_i  (odd_addr),
    .wdata_i (wr_word),
    .rdata_o (odd_rd)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= RESET_STATE;
      len_lo_q   <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      byte_cnt_q <= '0;
      word_buf_q <= '0;
      ready_q    <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      swap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      byte_cnt_q <= byte_cnt_d;
      word_buf_q <= word_buf_d;
      ready_q    <= (state_d != BOOT_RUN);
      hold_q     <= (state_d != BOOT_RUN);
      done_q     <= (state_d == BOOT_RUN);
      rd_en_q    <= run;
      swap_q     <= addr_i[0];
    end
  end

  always_comb begin
    data_o = '0;
    if (rd_en_q) begin
      data_o = swap_q ? {even_rd, odd_rd} : {odd_rd, even_rd};
    end
  end

  assign load_ready_o = ready_q;
  assign core_hold_o  = hold_q;
  assign load_done_o  = done_q;

endmodule

// File: tb/tb_imem_dual_fetch.sv
// Bench for imem_dual_fetch: boot loads through the byte port, then fetches
// checked against a word model through an expected-value queue.
module tb_imem_dual_fetch;

  localparam int DEPTH = 1024;
  localparam logic [31:0] PROG [4] = '{32'h0000_0013, 32'h0010_0093,
                                       32'h0020_0113, 32'h0030_0193};

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [9:0]  addr_i = '0;
  logic [63:0] data_o;
  logic        load_valid_i = 1'b0;
  logic [7:0]  load_data_i = '0;
  logic        load_ready_o, core_hold_o, load_done_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_mem [DEPTH];

  imem_dual_fetch dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .addr_i       (addr_i),
    .data_o       (data_o),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_ready_o (load_ready_o),
    .core_hold_o  (core_hold_o),
    .load_done_o  (load_done_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clock_i = ~clock_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i      = 1'b1;
    load_valid_i = 1'b0;
    tick();
    reset_i = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    load_valid_i = 1'b1;
    load_data_i  = b;
    while (load_ready_o !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    checks++;
    if (load_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: load_ready_o=%b required 1", load_ready_o);
    end
    tick();
    load_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit toggle, input int mid_gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (toggle) tick();
      if (i == 1) repeat (mid_gap) tick();
    end
  endtask

  task automatic drive_fetch(input int a);
    addr_i = 10'(a);
    exp_q.push_back({model_mem[(a + 1) % DEPTH], model_mem[a]});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    checks++;
    if (core_hold_o !== 1'b1 || load_ready_o !== 1'b0 || load_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: hold=%b ready=%b done=%b required 1 0 0",
               core_hold_o, load_ready_o, load_done_o);
    end
    checks++;
    if (data_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: data_o=%h required 0", data_o);
    end
    reset_i = 1'b0;
    tick();
    checks++;
    if (load_ready_o !== 1'b1 || core_hold_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_next: ready=%b hold=%b required 1 1", load_ready_o, core_hold_o);
    end
  endtask

  task automatic test_basic_load();
    logic [63:0] exp;
    send_byte(8'h04);
    send_byte(8'h00);
    for (int w = 0; w < 3; w++) begin
      send_word(PROG[w], 1'b0, 0);
      model_mem[w] = PROG[w];
    end
    for (int i = 0; i < 3; i++) send_byte(PROG[3][8*i +: 8]);
    checks++;
    if (load_done_o !== 1'b0 || core_hold_o !== 1'b1 || data_o !== 64'd0) begin
      errors++;
      $display("FAIL basic_pre_done: done=%b hold=%b data=%h required 0 1 0",
               load_done_o, core_hold_o, data_o);
    end
    send_byte(PROG[3][31:24]);
    model_mem[3] = PROG[3];
    checks++;
    if (load_done_o !== 1'b1 || load_ready_o !== 1'b0 || core_hold_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b ready=%b hold=%b required 1 0 0",
               load_done_o, load_ready_o, core_hold_o);
    end
    for (int a = 0; a < 3; a++) begin
      drive_fetch(a);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (data_o !== exp) begin
        errors++;
        $display("FAIL basic_fetch a=%0d: data_o=%h required %h", a, data_o, exp);
      end
    end
  endtask

  task automatic test_run_ignores();
    logic [63:0] exp;
    load_valid_i = 1'b1;
    load_data_i  = 8'hAA;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (load_ready_o !== 1'b0 || load_done_o !== 1'b1) begin
        errors++;
        $display("FAIL run_ignore_ctrl: ready=%b done=%b required 0 1", load_ready_o, load_done_o);
      end
    end
    load_valid_i = 1'b0;
    drive_fetch(0);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (data_o !== exp) begin
      errors++;
      $display("FAIL run_ignore_fetch: data_o=%h required %h", data_o, exp);
    end
  endtask

  task automatic test_full_load();
    logic [63:0] exp;
    int addrs [2] = '{1023, 512};
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    for (int k = 0; k < DEPTH - 1; k++) begin
      send_word(32'(k), 1'b0, 0);
      model_mem[k] = 32'(k);
    end
    checks++;
    if (load_done_o !== 1'b0) begin
      errors++;
      $display("FAIL full_pre_done: done=%b required 0", load_done_o);
    end
    send_word(32'(DEPTH - 1), 1'b0, 0);
    model_mem[DEPTH - 1] = 32'(DEPTH - 1);
    checks++;
    if (load_done_o !== 1'b1) begin
      errors++;
      $display("FAIL full_done: done=%b required 1", load_done_o);
    end
    for (int i = 0; i < 2; i++) begin
      drive_fetch(addrs[i]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (data_o !== exp) begin
        errors++;
        $display("FAIL full_fetch a=%0d: data_o=%h required %h", addrs[i], data_o, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    int a;
    for (int i = 0; i < 24; i++) begin
      a = (i < 4) ? (1020 + i) : int'($urandom_range(0, DEPTH - 1));
      drive_fetch(a);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (data_o !== exp) begin
        errors++;
        $display("FAIL b2b_fetch a=%0d: data_o=%h required %h", a, data_o, exp);
      end
    end
  endtask

  task automatic test_gap_load();
    logic [63:0] exp;
    do_reset();
    send_byte(8'h04);
    tick();
    send_byte(8'h00);
    tick();
    for (int w = 0; w < 4; w++) begin
      send_word(PROG[w], 1'b1, (w == 2) ? 5 : 0);
      model_mem[w] = PROG[w];
    end
    checks++;
    if (load_done_o !== 1'b1 || core_hold_o !== 1'b0) begin
      errors++;
      $display("FAIL gap_done: done=%b hold=%b required 1 0", load_done_o, core_hold_o);
    end
    for (int a = 0; a < 4; a++) begin
      drive_fetch(a);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (data_o !== exp) begin
        errors++;
        $display("FAIL gap_fetch a=%0d: data_o=%h required %h", a, data_o, exp);
      end
    end
  endtask

  task automatic test_reset_midload();
    logic [63:0] exp;
    logic [31:0] beef = 32'hDEAD_BEEF;
    do_reset();
    send_byte(8'h04);
    send_byte(8'h00);
    send_word(32'h1111_1111, 1'b0, 0);
    model_mem[0] = 32'h1111_1111;
    send_byte(8'h22);
    send_byte(8'h22);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checks++;
    if (core_hold_o !== 1'b1 || load_done_o !== 1'b0 || data_o !== 64'd0) begin
      errors++;
      $display("FAIL midload_reset: hold=%b done=%b data=%h required 1 0 0",
               core_hold_o, load_done_o, data_o);
    end
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 3; i++) send_byte(beef[8*i +: 8]);
    checks++;
    if (load_done_o !== 1'b0) begin
      errors++;
      $display("FAIL midload_pre_done: done=%b required 0", load_done_o);
    end
    send_byte(beef[31:24]);
    model_mem[0] = beef;
    checks++;
    if (load_done_o !== 1'b1) begin
      errors++;
      $display("FAIL midload_done: done=%b required 1", load_done_o);
    end
    for (int a = 0; a < 2; a++) begin
      drive_fetch(a);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (data_o !== exp) begin
        errors++;
        $display("FAIL midload_fetch a=%0d: data_o=%h required %h", a, data_o, exp);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_load();
    test_run_ignores();
    test_full_load();
    test_back_to_back();
    test_gap_load();
    test_reset_midload();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
